// File: rtl/inner_function_driver_pkg.sv
// Shared types and constants for the inner_function custom-instruction driver.
package inner_function_driver_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  // Accelerator start->done latency (fp_mult 5 + cordic 17); the driver itself is latency-agnostic.
  localparam int LATENCY = 22;

  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ci_result_fifo.sv
// Synchronous first-word-fall-through FIFO collecting accelerator results.
module ci_result_fifo
  import inner_function_driver_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  localparam int CW = clog2p1(DEPTH),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             aclr_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // pop frees the slot first, so push on a full FIFO is legal when popping
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inner_function_driver.sv
// Streams a batch of samples into the start/done accelerator at full rate and
// collects the in-order returns into a host-drained result FIFO.
module inner_function_driver
  import inner_function_driver_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              go,
  input  logic [CNT_W-1:0]  len,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ci_clk_en,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  input  logic              ci_done,
  input  logic [DATA_W-1:0] ci_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              finished,
  output logic              err_spurious,
  output logic              err_timeout
);

  localparam int FC_W = clog2p1(FIFO_DEPTH);
  localparam int WD_W = clog2p1(TIMEOUT);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  len_q, issued;
  logic [FC_W-1:0]   inflight, fifo_count;
  logic [FC_W:0]     occupancy;
  logic [WD_W-1:0]   wd_cnt;
  logic              accept, ret_ok, spurious, wd_fire, go_idle;
  logic              fifo_empty, fifo_full;

  // Credit covers both queued and in-flight results, so a return always has a slot.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign in_ready  = (state == S_RUN) & (issued < len_q) & ~abort & ~fifo_full
                   & (occupancy < (FC_W+1)'(FIFO_DEPTH));
  assign accept    = in_valid & in_ready;
  assign ret_ok    = ci_done & (inflight != '0);
  assign spurious  = ci_done & (inflight == '0);
  assign wd_fire   = (inflight != '0) & ~ci_done & (wd_cnt == WD_W'(TIMEOUT - 1));
  assign go_idle   = go & (state == S_IDLE);
  assign rsp_valid = ~fifo_empty;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (go) state_nx = (len == '0) ? S_FIN : S_RUN;
      S_RUN:   if ((issued == len_q) || abort) state_nx = S_DRAIN;
      S_DRAIN: if (inflight == '0) state_nx = S_FIN;
      default: state_nx = S_IDLE;
    endcase
    if (wd_fire) state_nx = S_FIN;
  end

  always_comb begin
    busy     = (state != S_IDLE);
    finished = (state == S_FIN);
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      len_q        <= '0;
      issued       <= '0;
      inflight     <= '0;
      wd_cnt       <= '0;
      err_spurious <= 1'b0;
      err_timeout  <= 1'b0;
      ci_start     <= 1'b0;
      ci_dataa     <= '0;
      ci_clk_en    <= 1'b0;
    end else begin
      ci_clk_en <= 1'b1;
      ci_start  <= accept;
      if (accept) ci_dataa <= in_data;

      if (go_idle) begin
        len_q  <= len;
        issued <= '0;
      end else if (accept) begin
        issued <= issued + 1'b1;
      end

      // A watchdog fire abandons outstanding work; late returns then read as spurious.
      if (wd_fire) inflight <= '0;
      else if (accept & ~ret_ok) inflight <= inflight + 1'b1;
      else if (~accept & ret_ok) inflight <= inflight - 1'b1;

      if (wd_fire || ci_done || inflight == '0) wd_cnt <= '0;
      else                                      wd_cnt <= wd_cnt + 1'b1;

      if (spurious)     err_spurious <= 1'b1;
      else if (go_idle) err_spurious <= 1'b0;
      if (wd_fire)      err_timeout  <= 1'b1;
      else if (go_idle) err_timeout  <= 1'b0;
    end
  end

  ci_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .aclr_n    (aclr_n),
    .push      (ret_ok),
    .push_data (ci_result),
    .pop       (rsp_ready),
    .pop_data  (rsp_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule
